// File: rtl/platform_rider.sv
// -----------------------------------------------------------------------------
// platform_rider
//
// Tracks one frog against one moving river platform. The frog rides the
// platform while it sits in the platform lane and overlaps it. Each
// platform step carries the frog one pixel left. A frog that is in the
// lane but off the platform sinks after a grace period. A frog carried
// past the left river boundary drowns.
//
// Ports
//   Reset        in   1  asynchronous active-high reset
//   frame_clk    in   1  clock
//   frog_hop     in   1  one-cycle pulse; frogX_in/frogY_in hold a new position
//   frogX_in     in  10  hop target X
//   frogY_in     in  10  hop target Y
//   platX        in  10  platform left-edge X (already updated on plat_moved)
//   platY        in  10  platform lane Y
//   plat_moved   in   1  one-cycle pulse; platform moved 1 px left
//   frogX_out    out 10  current frog X
//   frogY_out    out 10  current frog Y
//   riding       out  1  frog is riding the platform
//   drowned      out  1  frog has drowned (terminal until Reset)
//   carry_count  out  8  pixels carried since last hop, saturating at 255
// -----------------------------------------------------------------------------
module platform_rider #(
    parameter int PLAT_W       = 32,
    parameter int FROG_W       = 16,
    parameter int RIVER_LEFT   = 207,
    parameter int FROG_START_X = 320,
    parameter int FROG_START_Y = 400,
    parameter int SINK_DELAY   = 1250000
) (
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       frog_hop,
    input  logic [9:0] frogX_in,
    input  logic [9:0] frogY_in,
    input  logic [9:0] platX,
    input  logic [9:0] platY,
    input  logic       plat_moved,
    output logic [9:0] frogX_out,
    output logic [9:0] frogY_out,
    output logic       riding,
    output logic       drowned,
    output logic [7:0] carry_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RIDING  = 2'd1,
        S_SINKING = 2'd2,
        S_DROWNED = 2'd3
    } state_t;

    localparam logic [10:0] C_PLAT_W     = 11'(PLAT_W);
    localparam logic [10:0] C_FROG_W     = 11'(FROG_W);
    localparam logic [9:0]  C_RIVER_LEFT = 10'(RIVER_LEFT);
    localparam logic [9:0]  C_START_X    = 10'(FROG_START_X);
    localparam logic [9:0]  C_START_Y    = 10'(FROG_START_Y);
    localparam logic [21:0] C_SINK_LAST  = 22'(SINK_DELAY - 1);

    state_t      r_state;
    logic [9:0]  r_frog_x;
    logic [9:0]  r_frog_y;
    logic [7:0]  r_carry;
    logic [21:0] r_sink_cnt;
    // Set when the last carry step left the frog past the river edge; the
    // drown itself is taken on the following edge.
    logic        r_drown_pend;

    logic        w_in_lane;
    logic        w_overlap;
    logic [9:0]  w_x_dec;

    assign w_in_lane = (r_frog_y == platY);
    // Both sums are widened to 11 bits so a platform near X=1023 cannot wrap.
    assign w_overlap = (({1'b0, r_frog_x} + C_FROG_W) > {1'b0, platX}) &&
                       ({1'b0, r_frog_x} < ({1'b0, platX} + C_PLAT_W));
    assign w_x_dec   = r_frog_x - 10'd1;

    // Frog state machine: position, carry count, sink timer and state.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_frog_x     <= C_START_X;
            r_frog_y     <= C_START_Y;
            r_carry      <= 8'd0;
            r_sink_cnt   <= 22'd0;
            r_drown_pend <= 1'b0;
        end else if (r_state == S_DROWNED) begin
            // Terminal: hops and platform motion are ignored, everything holds.
            r_state <= S_DROWNED;
        end else if (frog_hop) begin
            // A hop wins over a simultaneous platform step. The FSM restarts
            // from IDLE so the new position is judged on the next edge.
            r_frog_x     <= frogX_in;
            r_frog_y     <= frogY_in;
            r_carry      <= 8'd0;
            r_sink_cnt   <= 22'd0;
            r_drown_pend <= 1'b0;
            r_state      <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_lane && w_overlap) begin
                        r_state <= S_RIDING;
                    end else if (w_in_lane) begin
                        r_state    <= S_SINKING;
                        r_sink_cnt <= 22'd0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RIDING: begin
                    if (r_drown_pend) begin
                        r_state <= S_DROWNED;
                    end else if (!w_in_lane) begin
                        r_state <= S_IDLE;
                    end else if (!w_overlap) begin
                        // Covers the platform wrapping back to the right.
                        r_state    <= S_SINKING;
                        r_sink_cnt <= 22'd0;
                    end else if (plat_moved) begin
                        r_frog_x     <= w_x_dec;
                        r_carry      <= (r_carry == 8'd255) ? 8'd255 : (r_carry + 8'd1);
                        r_drown_pend <= (w_x_dec < C_RIVER_LEFT);
                    end else begin
                        r_state <= S_RIDING;
                    end
                end
                S_SINKING: begin
                    if (w_in_lane && w_overlap) begin
                        r_state <= S_RIDING;
                    end else if (!w_in_lane) begin
                        r_state <= S_IDLE;
                    end else if (r_sink_cnt == C_SINK_LAST) begin
                        r_state <= S_DROWNED;
                    end else begin
                        r_sink_cnt <= r_sink_cnt + 22'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign frogX_out   = r_frog_x;
    assign frogY_out   = r_frog_y;
    assign carry_count = r_carry;
    assign riding      = (r_state == S_RIDING);
    assign drowned     = (r_state == S_DROWNED);

endmodule

// File: tb/tb_platform_rider.sv
module tb_platform_rider;

    localparam int PLAT_W     = 32;
    localparam int FROG_W     = 16;
    localparam int RIVER_LEFT = 207;
    localparam int START_X    = 320;
    localparam int START_Y    = 400;
    localparam int SD         = 4;

    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       frog_hop = 1'b0;
    logic [9:0] frogX_in = 10'd0;
    logic [9:0] frogY_in = 10'd0;
    logic [9:0] platX = 10'd300;
    logic [9:0] platY = 10'd182;
    logic       plat_moved = 1'b0;
    logic [9:0] frogX_out;
    logic [9:0] frogY_out;
    logic       riding;
    logic       drowned;
    logic [7:0] carry_count;

    platform_rider #(
        .PLAT_W(PLAT_W), .FROG_W(FROG_W), .RIVER_LEFT(RIVER_LEFT),
        .FROG_START_X(START_X), .FROG_START_Y(START_Y), .SINK_DELAY(SD)
    ) dut (
        .Reset(Reset), .frame_clk(frame_clk), .frog_hop(frog_hop),
        .frogX_in(frogX_in), .frogY_in(frogY_in), .platX(platX), .platY(platY),
        .plat_moved(plat_moved), .frogX_out(frogX_out), .frogY_out(frogY_out),
        .riding(riding), .drowned(drowned), .carry_count(carry_count)
    );

    always #5 frame_clk = ~frame_clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int M_IDLE = 0, M_RIDE = 1, M_SINK = 2, M_DROWN = 3;
    int m_mode = M_IDLE;
    int mx = START_X, my = START_Y, mcarry = 0;
    int m_cyc = 0, m_sink_start = 0;
    bit m_past_edge = 1'b0;

    initial begin
        bit lane, ov;
        forever begin
            @(posedge frame_clk or posedge Reset);
            if (Reset) begin
                m_mode = M_IDLE; mx = START_X; my = START_Y; mcarry = 0;
                m_past_edge = 1'b0;
            end else begin
                m_cyc++;
                lane = (my == int'(platY));
                ov   = (mx + FROG_W > int'(platX)) && (mx < int'(platX) + PLAT_W);
                if (m_mode == M_DROWN) begin
                    m_mode = M_DROWN;
                end else if (frog_hop) begin
                    mx = int'(frogX_in); my = int'(frogY_in); mcarry = 0;
                    m_past_edge = 1'b0; m_mode = M_IDLE;
                end else if (m_mode == M_IDLE) begin
                    if (lane && ov) m_mode = M_RIDE;
                    else if (lane) begin m_mode = M_SINK; m_sink_start = m_cyc; end
                end else if (m_mode == M_RIDE) begin
                    if (m_past_edge) m_mode = M_DROWN;
                    else if (!lane) m_mode = M_IDLE;
                    else if (!ov) begin m_mode = M_SINK; m_sink_start = m_cyc; end
                    else if (plat_moved) begin
                        mx = mx - 1;
                        mcarry = (mcarry + 1 > 255) ? 255 : mcarry + 1;
                        m_past_edge = (mx < RIVER_LEFT);
                    end
                end else begin
                    if (lane && ov) m_mode = M_RIDE;
                    else if (!lane) m_mode = M_IDLE;
                    else if (m_cyc - m_sink_start >= SD) m_mode = M_DROWN;
                end
            end
        end
    end

    // Compare DUT against model on every falling edge.
    always @(negedge frame_clk) begin
        if (chk_en) begin
            chk("cmp_frogX", int'(frogX_out), mx);
            chk("cmp_frogY", int'(frogY_out), my);
            chk("cmp_carry", int'(carry_count), mcarry);
            chk("cmp_riding", int'(riding), (m_mode == M_RIDE) ? 1 : 0);
            chk("cmp_drowned", int'(drowned), (m_mode == M_DROWN) ? 1 : 0);
            chk("cmp_exclusive", int'(riding & drowned), 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input bit hop, input int hx, input int hy, input bit mv);
        frog_hop   = hop;
        frogX_in   = 10'(hx);
        frogY_in   = 10'(hy);
        plat_moved = mv;
        if (mv) platX = platX - 10'd1;
        @(posedge frame_clk);
        #2;
        frog_hop   = 1'b0;
        plat_moved = 1'b0;
    endtask

    task automatic do_reset();
        frog_hop   = 1'b0;
        plat_moved = 1'b0;
        Reset      = 1'b1;
        @(posedge frame_clk);
        @(posedge frame_clk);
        #2;
        Reset = 1'b0;
    endtask

    initial begin
        int r, hx, hy;
        bit hop, mv;

        do_reset();
        chk_en = 1'b1;
        chk("rst_x", int'(frogX_out), 320);
        chk("rst_y", int'(frogY_out), 400);
        chk("rst_riding", int'(riding), 0);
        chk("rst_drowned", int'(drowned), 0);
        chk("rst_carry", int'(carry_count), 0);

        // Board: hop onto platform
        platX = 10'd300;
        cyc(1'b1, 310, 182, 1'b0);
        cyc(1'b0, 0, 0, 1'b0);
        chk("board_riding", int'(riding), 1);

        // Carry five pixels
        for (int k = 0; k < 5; k++) cyc(1'b0, 0, 0, 1'b1);
        chk("carry_x", int'(frogX_out), 305);
        chk("carry_cnt", int'(carry_count), 5);

        // Collision: hop and plat_moved together
        platX = 10'd300;
        cyc(1'b1, 310, 182, 1'b0);
        cyc(1'b0, 0, 0, 1'b0);
        cyc(1'b1, 330, 182, 1'b1);
        chk("coll_x", int'(frogX_out), 330);
        chk("coll_carry", int'(carry_count), 0);

        // Edge drown
        platX = 10'd200;
        cyc(1'b1, 208, 182, 1'b0);
        cyc(1'b0, 0, 0, 1'b0);
        chk("edge_riding", int'(riding), 1);
        cyc(1'b0, 0, 0, 1'b1);
        chk("edge_x207", int'(frogX_out), 207);
        cyc(1'b0, 0, 0, 1'b1);
        chk("edge_x206", int'(frogX_out), 206);
        chk("edge_not_yet", int'(drowned), 0);
        cyc(1'b0, 0, 0, 1'b0);
        chk("edge_drowned", int'(drowned), 1);
        chk("edge_not_riding", int'(riding), 0);
        cyc(1'b1, 310, 182, 1'b0);
        chk("edge_hop_ignored", int'(frogX_out), 206);
        chk("edge_carry_held", int'(carry_count), 2);

        // Sink to drown
        do_reset();
        platX = 10'd300;
        cyc(1'b1, 100, 182, 1'b0);
        cyc(1'b0, 0, 0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 0, 0, 1'b0);
        chk("sink_3cyc", int'(drowned), 0);
        cyc(1'b0, 0, 0, 1'b0);
        chk("sink_4cyc", int'(drowned), 1);

        // Sink then hop out of lane
        do_reset();
        cyc(1'b1, 100, 182, 1'b0);
        cyc(1'b0, 0, 0, 1'b0);
        cyc(1'b0, 0, 0, 1'b0);
        cyc(1'b0, 0, 0, 1'b0);
        cyc(1'b1, 100, 250, 1'b0);
        for (int k = 0; k < 6; k++) cyc(1'b0, 0, 0, 1'b0);
        chk("escape_no_drown", int'(drowned), 0);
        chk("escape_y", int'(frogY_out), 250);

        // Platform wrap while riding
        do_reset();
        cyc(1'b1, 310, 182, 1'b0);
        cyc(1'b0, 0, 0, 1'b0);
        platX = 10'd600;
        for (int k = 0; k < 6; k++) cyc(1'b0, 0, 0, 1'b0);
        chk("wrap_x", int'(frogX_out), 310);
        chk("wrap_drowned", int'(drowned), 1);

        // Asynchronous reset mid-sink
        do_reset();
        platX = 10'd300;
        cyc(1'b1, 100, 182, 1'b0);
        cyc(1'b0, 0, 0, 1'b0);
        cyc(1'b0, 0, 0, 1'b0);
        cyc(1'b0, 0, 0, 1'b0);
        #1 Reset = 1'b1;
        #1;
        chk("async_x", int'(frogX_out), 320);
        chk("async_y", int'(frogY_out), 400);
        chk("async_drowned", int'(drowned), 0);
        chk("async_riding", int'(riding), 0);
        chk("async_carry", int'(carry_count), 0);
        @(posedge frame_clk);
        #2 Reset = 1'b0;

        // Randomized phase
        platX = 10'd300;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if ((m_mode == M_DROWN && r < 15) || r == 0) begin
                do_reset();
            end else begin
                hop = ($urandom_range(0, 99) < 10);
                hx  = int'(platX) + int'($urandom_range(0, 70)) - 30;
                hy  = ($urandom_range(0, 3) == 0) ? 250 : 182;
                mv  = ($urandom_range(0, 99) < 40);
                if (platX <= 10'd100) begin
                    mv    = 1'b0;
                    platX = 10'd500;
                end else if ($urandom_range(0, 99) < 2 && platX < 10'd400) begin
                    platX = platX + 10'd300;
                end
                cyc(hop, hx, hy, mv);
            end
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/platform_rider.md
PLATFORM_RIDER -- requirements
Module: platform_rider

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- PLAT_W, 32: platform width in pixels.
- FROG_W, 16: frog width in pixels.
- RIVER_LEFT, 207: left river boundary X.
- FROG_START_X, 320: frog X at reset.
- FROG_START_Y, 400: frog Y at reset.
- SINK_DELAY, 1250000: grace cycles in lane without support.
REQ-002 Ports (name, direction, width, meaning), clock and reset first; reset Reset, asynchronous, active-high; clock frame_clk:
- Reset, in, 1: asynchronous active-high reset.
- frame_clk, in, 1: clock.
- frog_hop, in, 1: one-cycle pulse; frogX_in/frogY_in hold a committed new frog position.
- frogX_in, in, 10: hop target X.
- frogY_in, in, 10: hop target Y.
- platX, in, 10: platform left-edge X.
- platY, in, 10: platform lane Y (constant per instance).
- plat_moved, in, 1: one-cycle pulse; platform moved 1 px left this cycle (platX already updated).
- frogX_out, out, 10: current frog X.
- frogY_out, out, 10: current frog Y.
- riding, out, 1: high while in RIDING.
- drowned, out, 1: high while in DROWNED.
- carry_count, out, 8: pixels carried since last hop, saturating.

Function
REQ-003 Four-state FSM: IDLE, RIDING, SINKING, DROWNED; state encoding internal.
REQ-004 in_lane = (frogY_out == platY); overlap = (frogX_out + FROG_W > platX) and (frogX_out < platX + PLAT_W); sums evaluated at 11 bits, no wrap.
REQ-005 frog_hop in any state except DROWNED: frogX_out <= frogX_in, frogY_out <= frogY_in, carry_count <= 0; state re-evaluated the next cycle from the new position.
REQ-006 frog_hop in DROWNED: ignored; positions frozen.
REQ-007 IDLE: in_lane and overlap -> RIDING; in_lane and not overlap -> SINKING with sink counter cleared; otherwise stay.
REQ-008 RIDING: plat_moved without frog_hop -> frogX_out decrements by 1 and carry_count increments, saturating at 255.
REQ-009 RIDING: not in_lane -> IDLE; in_lane and not overlap -> SINKING with counter cleared.
REQ-010 RIDING: a decrement that makes frogX_out < RIVER_LEFT -> DROWNED on the next edge.
REQ-011 plat_moved and frog_hop in the same cycle: hop wins, no decrement.
REQ-012 Platform wrap (platX jumps right): no frog teleport. Overlap is lost, so the FSM goes to SINKING unless the frog has already drowned.
REQ-013 SINKING: 22-bit counter increments every cycle. Overlap regained -> RIDING. Not in_lane -> IDLE. Counter reaching SINK_DELAY-1 with neither condition -> DROWNED.
REQ-014 DROWNED: terminal until Reset; riding=0, drowned=1, carry_count held.
REQ-015 riding and drowned are Moore outputs decoded from registered state; they are never both high.
REQ-016 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-017 Reset asserted asynchronously at any time, including mid-SINKING or mid-carry: state=IDLE, frogX_out=FROG_START_X, frogY_out=FROG_START_Y, riding=0, drowned=0, carry_count=0, sink counter=0.
REQ-018 First evaluation occurs on the first frame_clk edge after Reset deasserts.

Verification (bench uses SINK_DELAY=4)
REQ-019 Board: platY=182, platX=300; hop to (310,182) -> RIDING within 2 cycles; riding=1.
REQ-020 Carry: RIDING at X=310; 5 plat_moved pulses, platX tracking -> frogX_out=305, carry_count=5.
REQ-021 Edge drown: RIDING at X=208, platX=200; plat_moved -> X=207; plat_moved -> X=206 -> drowned=1 next edge; a later hop is ignored.
REQ-022 Sink: hop to (100,182) with platX=300 -> SINKING; drowned=1 exactly 4 cycles after SINKING entry. Repeat with a hop to Y=250 after 2 cycles -> IDLE, no drown.
REQ-023 Collision: RIDING X=310; frog_hop to (330,182) and plat_moved in the same cycle -> frogX_out=330, carry_count=0.
REQ-024 Reset mid-SINKING after 2 cycles -> all outputs return to reset values immediately, without waiting for a clock edge.
